// File: rtl/wired_ftq_ring.sv
// Fetch target queue: circular buffer of predicted fetch blocks between the BPU and fetch.
// Define WIRED_FTQ_PERF_EN to add the saturating perf_redir_o / perf_full_o counters.
module wired_ftq_ring #(
  parameter int DEPTH   = 16,
  parameter int VA_W    = 32,
  parameter int FETCH_W = 4,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int LEN_W   = $clog2(FETCH_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [VA_W-1:0]  enq_pc_i,
  input  logic [LEN_W-1:0] enq_len_i,
  input  logic             enq_taken_i,
  input  logic [VA_W-1:0]  enq_target_i,
  output logic [IDX_W-1:0] enq_idx_o,
  input  logic             acc_valid_i,
  input  logic [IDX_W-1:0] acc_idx_i,
  input  logic [LEN_W-1:0] acc_len_i,
  input  logic             acc_taken_i,
  input  logic [VA_W-1:0]  acc_target_i,
  output logic             redir_valid_o,
  output logic [VA_W-1:0]  redir_pc_o,
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  output logic [VA_W-1:0]  fetch_pc_o,
  output logic [LEN_W-1:0] fetch_len_o,
  output logic [IDX_W-1:0] fetch_idx_o,
  input  logic             cmt_valid_i,
  output logic             cmt_ready_o,
  output logic             upd_valid_o,
  input  logic             upd_ready_i,
  output logic [VA_W-1:0]  upd_pc_o,
  output logic [LEN_W-1:0] upd_len_o,
  output logic             upd_taken_o,
  output logic [VA_W-1:0]  upd_target_o,
  output logic [IDX_W:0]   count_o
`ifdef WIRED_FTQ_PERF_EN
  ,
  output logic [31:0]      perf_redir_o,
  output logic [31:0]      perf_full_o
`endif
);

  localparam logic [IDX_W:0] PTR_ONE   = 1;
  localparam logic [IDX_W:0] PTR_DEPTH = (IDX_W + 1)'(DEPTH);

  logic [VA_W-1:0]  pc_mem     [DEPTH];
  logic [LEN_W-1:0] len_mem    [DEPTH];
  logic             taken_mem  [DEPTH];
  logic [VA_W-1:0]  target_mem [DEPTH];

  logic [IDX_W:0]   head;
  logic [IDX_W:0]   fptr;
  logic [IDX_W:0]   tail;
  logic [IDX_W:0]   count;
  logic             full;
  logic             enq_fire;
  logic             fetch_fire;
  logic             can_retire;
  logic             retire;
  logic [IDX_W-1:0] acc_off;
  logic [IDX_W:0]   acc_ptr;
  logic [IDX_W:0]   fptr_fired;
  logic [IDX_W:0]   fired_off;
  logic             acc_ok;
  logic [VA_W-1:0]  acc_redir_pc;

  // Offsets are taken relative to head so that range checks and the fetch
  // rewind compare ages in the ring rather than raw wrapped indices.
  always_comb begin
    count         = tail - head;
    full          = (count == PTR_DEPTH);
    enq_ready_o   = !full && !acc_valid_i && !flush_i;
    enq_fire      = enq_valid_i && enq_ready_o;
    fetch_valid_o = (fptr != tail);
    fetch_fire    = fetch_valid_o && fetch_ready_i;
    can_retire    = (head != fptr);
    upd_valid_o   = cmt_valid_i && can_retire;
    cmt_ready_o   = upd_ready_i && can_retire;
    retire        = cmt_valid_i && cmt_ready_o;
    acc_off       = acc_idx_i - head[IDX_W-1:0];
    acc_ptr       = head + {1'b0, acc_off};
    fptr_fired    = fptr + {{IDX_W{1'b0}}, fetch_fire};
    fired_off     = fptr_fired - head;
    acc_ok        = acc_valid_i && !flush_i && ({1'b0, acc_off} < count)
                    && !(retire && (acc_off == '0));
    acc_redir_pc  = acc_taken_i ? acc_target_i
                                : pc_mem[acc_idx_i] + (VA_W'(acc_len_i) << 2);
  end

  always_comb begin
    enq_idx_o    = tail[IDX_W-1:0];
    fetch_idx_o  = fptr[IDX_W-1:0];
    fetch_pc_o   = pc_mem[fptr[IDX_W-1:0]];
    fetch_len_o  = len_mem[fptr[IDX_W-1:0]];
    upd_pc_o     = pc_mem[head[IDX_W-1:0]];
    upd_len_o    = len_mem[head[IDX_W-1:0]];
    upd_taken_o  = taken_mem[head[IDX_W-1:0]];
    upd_target_o = target_mem[head[IDX_W-1:0]];
    count_o      = count;
  end

  // A correction truncates everything younger than the corrected entry and
  // pulls fetch back to it if fetch had already moved past.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      fptr          <= '0;
      tail          <= '0;
      redir_valid_o <= 1'b0;
      redir_pc_o    <= '0;
    end else if (flush_i) begin
      head          <= '0;
      fptr          <= '0;
      tail          <= '0;
      redir_valid_o <= 1'b0;
      redir_pc_o    <= '0;
    end else begin
      redir_valid_o <= acc_ok;
      if (acc_ok) begin
        redir_pc_o <= acc_redir_pc;
        tail       <= acc_ptr + PTR_ONE;
        fptr       <= (fired_off > {1'b0, acc_off}) ? acc_ptr : fptr_fired;
      end else begin
        if (enq_fire) begin
          tail <= tail + PTR_ONE;
        end
        if (fetch_fire) begin
          fptr <= fptr_fired;
        end
      end
      if (retire) begin
        head <= head + PTR_ONE;
      end
    end
  end

  // Entry storage carries no reset; only slots between head and tail are ever read as valid.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[tail[IDX_W-1:0]]     <= enq_pc_i;
      len_mem[tail[IDX_W-1:0]]    <= enq_len_i;
      taken_mem[tail[IDX_W-1:0]]  <= enq_taken_i;
      target_mem[tail[IDX_W-1:0]] <= enq_target_i;
    end else if (acc_ok) begin
      len_mem[acc_idx_i]    <= acc_len_i;
      taken_mem[acc_idx_i]  <= acc_taken_i;
      target_mem[acc_idx_i] <= acc_target_i;
    end
  end

`ifdef WIRED_FTQ_PERF_EN
  // Counters survive flush so they measure the whole run since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redir_o <= '0;
      perf_full_o  <= '0;
    end else begin
      if (acc_ok && (perf_redir_o != '1)) begin
        perf_redir_o <= perf_redir_o + 32'd1;
      end
      if (enq_valid_i && full && !flush_i && (perf_full_o != '1)) begin
        perf_full_o <= perf_full_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wired_ftq_ring.sv
// Self-checking bench for wired_ftq_ring: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_wired_ftq_ring;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  len;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_pc = '0;
  logic [2:0]  enq_len = 3'd1;
  logic        enq_taken = 1'b0;
  logic [31:0] enq_target = '0;
  logic [3:0]  enq_idx;
  logic        acc_valid = 1'b0;
  logic [3:0]  acc_idx = '0;
  logic [2:0]  acc_len = 3'd1;
  logic        acc_taken = 1'b0;
  logic [31:0] acc_target = '0;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_pc;
  logic [2:0]  fetch_len;
  logic [3:0]  fetch_idx;
  logic        cmt_valid = 1'b0;
  logic        cmt_ready;
  logic        upd_valid;
  logic        upd_ready = 1'b0;
  logic [31:0] upd_pc;
  logic [2:0]  upd_len;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [4:0]  count;
`ifdef WIRED_FTQ_PERF_EN
  logic [31:0] perf_redir;
  logic [31:0] perf_full;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of live blocks, oldest first
  ent_t        mq[$];
  int          m_head = 0;
  int          m_nf = 0;
  logic        m_redir = 1'b0;
  logic [31:0] m_redir_pc = '0;

  wired_ftq_ring dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_pc_i(enq_pc),
    .enq_len_i(enq_len), .enq_taken_i(enq_taken), .enq_target_i(enq_target),
    .enq_idx_o(enq_idx),
    .acc_valid_i(acc_valid), .acc_idx_i(acc_idx), .acc_len_i(acc_len),
    .acc_taken_i(acc_taken), .acc_target_i(acc_target),
    .redir_valid_o(redir_valid), .redir_pc_o(redir_pc),
    .fetch_valid_o(fetch_valid), .fetch_ready_i(fetch_ready), .fetch_pc_o(fetch_pc),
    .fetch_len_o(fetch_len), .fetch_idx_o(fetch_idx),
    .cmt_valid_i(cmt_valid), .cmt_ready_o(cmt_ready),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_pc_o(upd_pc),
    .upd_len_o(upd_len), .upd_taken_o(upd_taken), .upd_target_o(upd_target),
    .count_o(count)
`ifdef WIRED_FTQ_PERF_EN
    , .perf_redir_o(perf_redir), .perf_full_o(perf_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    flush = 1'b0; enq_valid = 1'b0; acc_valid = 1'b0;
    fetch_ready = 1'b0; cmt_valid = 1'b0; upd_ready = 1'b0;
  endtask

  task automatic model_step();
    int sz;
    int off;
    bit fire, ret, ok, enq;
    ent_t e;
    sz = mq.size();
    if (flush) begin
      mq.delete(); m_head = 0; m_nf = 0; m_redir = 1'b0; m_redir_pc = '0;
      return;
    end
    fire = (m_nf < sz) && fetch_ready;
    ret  = cmt_valid && upd_ready && (m_nf > 0);
    off  = (int'(acc_idx) - m_head + DEPTH) % DEPTH;
    ok   = acc_valid && (off < sz) && !(ret && off == 0);
    enq  = enq_valid && (sz < DEPTH) && !acc_valid;
    if (fire) m_nf++;
    m_redir = ok;
    if (ok) begin
      e = mq[off];
      e.len = acc_len; e.taken = acc_taken; e.target = acc_target;
      mq[off] = e;
      while (mq.size() > off + 1) void'(mq.pop_back());
      if (m_nf > off) m_nf = off;
      m_redir_pc = acc_taken ? acc_target : e.pc + {27'b0, acc_len, 2'b00};
    end
    if (enq) begin
      e.pc = enq_pc; e.len = enq_len; e.taken = enq_taken; e.target = enq_target;
      mq.push_back(e);
    end
    if (ret) begin
      void'(mq.pop_front());
      m_nf--;
      m_head = (m_head + 1) % DEPTH;
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled only around the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_head = 0; m_nf = 0; m_redir = 1'b0; m_redir_pc = '0;
  endtask

  task automatic enqueue_block(input logic [31:0] pc, input logic [2:0] len);
    enq_valid = 1'b1; enq_pc = pc; enq_len = len; enq_taken = 1'b0; enq_target = '0;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmt_valid = 1'b1; upd_ready = 1'b1;
    #1;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
    n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_redir_valid: got %b want 0", redir_valid); end
    n_cmp++; if (redir_pc !== 32'h0) begin n_err++; $display("[TB] FAIL reset_redir_pc: got %h want 0", redir_pc); end
    n_cmp++; if (upd_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_upd_valid: got %b want 0", upd_valid); end
    n_cmp++; if (cmt_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_cmt_ready: got %b want 0", cmt_ready); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_enq_ready: got %b want 1", enq_ready); end
    n_cmp++; if (enq_idx !== 4'd0) begin n_err++; $display("[TB] FAIL reset_enq_idx: got %0d want 0", enq_idx); end
    idle();
  endtask

  task automatic test_basic_enqueue();
    do_reset();
    enq_valid = 1'b1; enq_pc = 32'h1000; enq_len = 3'd4;
    #1;
    n_cmp++; if (enq_idx !== 4'd0) begin n_err++; $display("[TB] FAIL basic_idx0: got %0d want 0", enq_idx); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("[TB] FAIL basic_fv_early: got %b want 0", fetch_valid); end
    tick();
    enq_pc = 32'h1010; enq_len = 3'd2; fetch_ready = 1'b1;
    #1;
    n_cmp++; if (enq_idx !== 4'd1) begin n_err++; $display("[TB] FAIL basic_idx1: got %0d want 1", enq_idx); end
    n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("[TB] FAIL basic_fv: got %b want 1", fetch_valid); end
    n_cmp++; if (fetch_pc !== 32'h1000) begin n_err++; $display("[TB] FAIL basic_pc0: got %h want 1000", fetch_pc); end
    n_cmp++; if (fetch_len !== 3'd4) begin n_err++; $display("[TB] FAIL basic_len0: got %0d want 4", fetch_len); end
    tick();
    enq_valid = 1'b0;
    #1;
    n_cmp++; if (fetch_pc !== 32'h1010) begin n_err++; $display("[TB] FAIL basic_pc1: got %h want 1010", fetch_pc); end
    n_cmp++; if (fetch_idx !== 4'd1) begin n_err++; $display("[TB] FAIL basic_fidx1: got %0d want 1", fetch_idx); end
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("[TB] FAIL basic_count: got %0d want 2", count); end
    tick();
    fetch_ready = 1'b0;
    #1;
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("[TB] FAIL basic_drained: got %b want 0", fetch_valid); end
    idle();
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      enq_valid = 1'b1; enq_pc = 32'h4000 + 32'(i * 16); enq_len = 3'd4;
      #1;
      n_cmp++; if (enq_idx !== 4'(i)) begin n_err++; $display("[TB] FAIL full_idx: got %0d want %0d", enq_idx, i); end
      tick();
    end
    #1;
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("[TB] FAIL full_count: got %0d want 16", count); end
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_ready: got %b want 0", enq_ready); end
    tick();
    enq_valid = 1'b0; fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0; cmt_valid = 1'b1; upd_ready = 1'b1;
    #1;
    n_cmp++; if (upd_valid !== 1'b1) begin n_err++; $display("[TB] FAIL full_upd_valid: got %b want 1", upd_valid); end
    n_cmp++; if (upd_pc !== 32'h4000) begin n_err++; $display("[TB] FAIL full_upd_pc: got %h want 4000", upd_pc); end
    tick();
    cmt_valid = 1'b0; enq_valid = 1'b1; enq_pc = 32'h9000;
    #1;
    n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_ready: got %b want 1", enq_ready); end
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("[TB] FAIL wrap_count: got %0d want 15", count); end
    n_cmp++; if (enq_idx !== 4'd0) begin n_err++; $display("[TB] FAIL wrap_idx: got %0d want 0", enq_idx); end
    tick();
    enq_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("[TB] FAIL wrap_refull: got %0d want 16", count); end
    idle();
  endtask

  task automatic test_correction();
    do_reset();
    for (int i = 0; i < 5; i++) enqueue_block(32'h3000 + 32'(i * 16), 3'd4);
    fetch_ready = 1'b1;
    repeat (3) tick();
    fetch_ready = 1'b0;
    acc_valid = 1'b1; acc_idx = 4'd1; acc_len = 3'd4; acc_taken = 1'b1; acc_target = 32'h2000;
    enq_valid = 1'b1; enq_pc = 32'hdead_0000;
    #1;
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("[TB] FAIL corr_enq_block: got %b want 0", enq_ready); end
    tick();
    acc_valid = 1'b0; enq_valid = 1'b0;
    #1;
    n_cmp++; if (redir_valid !== 1'b1) begin n_err++; $display("[TB] FAIL corr_redir: got %b want 1", redir_valid); end
    n_cmp++; if (redir_pc !== 32'h2000) begin n_err++; $display("[TB] FAIL corr_redir_pc: got %h want 2000", redir_pc); end
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("[TB] FAIL corr_count: got %0d want 2", count); end
    n_cmp++; if (fetch_idx !== 4'd1) begin n_err++; $display("[TB] FAIL corr_fidx: got %0d want 1", fetch_idx); end
    n_cmp++; if (fetch_pc !== 32'h3010) begin n_err++; $display("[TB] FAIL corr_fpc: got %h want 3010", fetch_pc); end
    tick();
    #1;
    n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL corr_pulse: got %b want 0", redir_valid); end
    acc_valid = 1'b1; acc_idx = 4'd0; acc_len = 3'd3; acc_taken = 1'b0;
    tick();
    acc_valid = 1'b0;
    #1;
    n_cmp++; if (redir_pc !== 32'h300c) begin n_err++; $display("[TB] FAIL corr_fall_pc: got %h want 300c", redir_pc); end
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("[TB] FAIL corr_fall_count: got %0d want 1", count); end
    n_cmp++; if (fetch_len !== 3'd3) begin n_err++; $display("[TB] FAIL corr_fall_len: got %0d want 3", fetch_len); end
    idle();
  endtask

  task automatic test_out_of_range();
    do_reset();
    enqueue_block(32'h6000, 3'd4);
    enqueue_block(32'h6010, 3'd4);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    acc_valid = 1'b1; acc_idx = 4'd2; acc_taken = 1'b1; acc_target = 32'h5555_0000; acc_len = 3'd1;
    tick();
    acc_idx = 4'd9;
    #1;
    n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL oor_tail_redir: got %b want 0", redir_valid); end
    tick();
    acc_valid = 1'b0;
    #1;
    n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL oor_far_redir: got %b want 0", redir_valid); end
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("[TB] FAIL oor_count: got %0d want 2", count); end
    n_cmp++; if (fetch_idx !== 4'd1) begin n_err++; $display("[TB] FAIL oor_fidx: got %0d want 1", fetch_idx); end
    cmt_valid = 1'b1; upd_ready = 1'b1; acc_valid = 1'b1; acc_idx = 4'd0;
    tick();
    idle();
    #1;
    n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL retiring_redir: got %b want 0", redir_valid); end
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("[TB] FAIL retiring_count: got %0d want 1", count); end
    n_cmp++; if (fetch_pc !== 32'h6010) begin n_err++; $display("[TB] FAIL retiring_fpc: got %h want 6010", fetch_pc); end
    idle();
  endtask

  task automatic test_commit_stall();
    do_reset();
    enqueue_block(32'h5000, 3'd2);
    enqueue_block(32'h5010, 3'd3);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0; cmt_valid = 1'b1; upd_ready = 1'b0;
    #1;
    n_cmp++; if (upd_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stall_upd_valid: got %b want 1", upd_valid); end
    n_cmp++; if (cmt_ready !== 1'b0) begin n_err++; $display("[TB] FAIL stall_cmt_ready: got %b want 0", cmt_ready); end
    n_cmp++; if (upd_pc !== 32'h5000) begin n_err++; $display("[TB] FAIL stall_upd_pc: got %h want 5000", upd_pc); end
    n_cmp++; if (upd_len !== 3'd2) begin n_err++; $display("[TB] FAIL stall_upd_len: got %0d want 2", upd_len); end
    tick();
    upd_ready = 1'b1;
    #1;
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("[TB] FAIL stall_hold: got %0d want 2", count); end
    tick();
    #1;
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("[TB] FAIL stall_retire: got %0d want 1", count); end
    n_cmp++; if (upd_valid !== 1'b0) begin n_err++; $display("[TB] FAIL unfetched_upd: got %b want 0", upd_valid); end
    n_cmp++; if (cmt_ready !== 1'b0) begin n_err++; $display("[TB] FAIL unfetched_ready: got %b want 0", cmt_ready); end
    tick();
    #1;
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("[TB] FAIL unfetched_hold: got %0d want 1", count); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) enqueue_block(32'h8000 + 32'(i * 16), 3'd4);
    fetch_ready = 1'b1;
    repeat (2) tick();
    flush = 1'b1; enq_valid = 1'b1; enq_pc = 32'hbeef_0000;
    acc_valid = 1'b1; acc_idx = 4'd1; acc_taken = 1'b1; acc_target = 32'h1234_0000;
    cmt_valid = 1'b1; upd_ready = 1'b1;
    #1;
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("[TB] FAIL flush_enq_ready: got %b want 0", enq_ready); end
    tick();
    idle();
    #1;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_fv: got %b want 0", fetch_valid); end
    n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_redir: got %b want 0", redir_valid); end
    n_cmp++; if (enq_idx !== 4'd0) begin n_err++; $display("[TB] FAIL flush_idx: got %0d want 0", enq_idx); end
    enqueue_block(32'h8800, 3'd1);
    #1;
    n_cmp++; if (fetch_pc !== 32'h8800) begin n_err++; $display("[TB] FAIL flush_refill: got %h want 8800", fetch_pc); end
    idle();
  endtask

  task automatic test_random();
    int sz;
    bit drain;
    ent_t e;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drain = ((i / 300) % 2) == 1;
      flush       = ($urandom_range(0, 199) == 0);
      enq_valid   = ($urandom_range(0, 9) < (drain ? 3 : 8));
      enq_pc      = $urandom() & 32'hffff_fffc;
      enq_len     = 3'($urandom_range(1, 4));
      enq_taken   = 1'($urandom_range(0, 1));
      enq_target  = $urandom() & 32'hffff_fffc;
      acc_valid   = ($urandom_range(0, 7) == 0);
      acc_idx     = 4'($urandom_range(0, 15));
      acc_len     = 3'($urandom_range(1, 4));
      acc_taken   = 1'($urandom_range(0, 1));
      acc_target  = $urandom() & 32'hffff_fffc;
      fetch_ready = ($urandom_range(0, 9) < (drain ? 8 : 3));
      cmt_valid   = ($urandom_range(0, 9) < (drain ? 8 : 3));
      upd_ready   = ($urandom_range(0, 9) < 7);
      #1;
      sz = mq.size();
      n_cmp++; if (count !== 5'(sz)) begin n_err++; $display("[TB] FAIL rnd_count @%0d: got %0d want %0d", i, count, sz); end
      n_cmp++; if (enq_ready !== ((sz < DEPTH) && !acc_valid && !flush)) begin n_err++; $display("[TB] FAIL rnd_enq_ready @%0d: got %b", i, enq_ready); end
      n_cmp++; if (enq_idx !== 4'((m_head + sz) % DEPTH)) begin n_err++; $display("[TB] FAIL rnd_enq_idx @%0d: got %0d want %0d", i, enq_idx, (m_head + sz) % DEPTH); end
      n_cmp++; if (fetch_valid !== (m_nf < sz)) begin n_err++; $display("[TB] FAIL rnd_fv @%0d: got %b", i, fetch_valid); end
      if (m_nf < sz) begin
        e = mq[m_nf];
        n_cmp++; if (fetch_pc !== e.pc || fetch_len !== e.len || fetch_idx !== 4'((m_head + m_nf) % DEPTH)) begin
          n_err++; $display("[TB] FAIL rnd_fetch @%0d: got %h/%0d/%0d want %h/%0d/%0d", i, fetch_pc, fetch_len, fetch_idx, e.pc, e.len, (m_head + m_nf) % DEPTH);
        end
      end
      n_cmp++; if (upd_valid !== (cmt_valid && m_nf > 0)) begin n_err++; $display("[TB] FAIL rnd_upd_valid @%0d: got %b", i, upd_valid); end
      n_cmp++; if (cmt_ready !== (upd_ready && m_nf > 0)) begin n_err++; $display("[TB] FAIL rnd_cmt_ready @%0d: got %b", i, cmt_ready); end
      if (cmt_valid && m_nf > 0) begin
        e = mq[0];
        n_cmp++; if (upd_pc !== e.pc || upd_len !== e.len || upd_taken !== e.taken || upd_target !== e.target) begin
          n_err++; $display("[TB] FAIL rnd_upd @%0d: got %h/%0d/%b/%h want %h/%0d/%b/%h", i, upd_pc, upd_len, upd_taken, upd_target, e.pc, e.len, e.taken, e.target);
        end
      end
      n_cmp++; if (redir_valid !== m_redir) begin n_err++; $display("[TB] FAIL rnd_redir @%0d: got %b want %b", i, redir_valid, m_redir); end
      if (m_redir) begin
        n_cmp++; if (redir_pc !== m_redir_pc) begin n_err++; $display("[TB] FAIL rnd_redir_pc @%0d: got %h want %h", i, redir_pc, m_redir_pc); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_enqueue();
    test_full_wrap();
    test_correction();
    test_out_of_range();
    test_commit_stall();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
